// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores to a multi-cycle data memory, stalls upstream
// while an access is outstanding, and registers the MEM/WB result fields.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] XOut_in,
    input  logic [15:0] read2Data_in,
    input  logic        MemWrite_in,
    input  logic        MemRead_in,
    input  logic        halt_in,
    input  logic        createdump_in,
    input  logic        link_in,
    input  logic [15:0] PC_plus_two_in,
    input  logic        MemtoReg_in,
    input  logic [2:0]  Write_register_in,
    input  logic        RegWrite_in,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        stall_out,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic [2:0]  wb_Write_register,
    output logic [15:0] wb_Write_data,
    output logic        wb_halt,
    output logic        wb_createdump,
    output logic        wb_err
);

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;
    typedef enum logic [1:0] {ENT_BUBBLE = 2'd0, ENT_NORMAL = 2'd1, ENT_ERROR = 2'd2} entry_t;

    state_t      state_r, state_s;
    entry_t      entry_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        memop_s, misalign_s;
    logic        rd_s, wr_s, stall_s;
    logic [15:0] wb_data_s;

    assign memop_s    = (MemRead_in | MemWrite_in) & ~XOut_in[0];
    assign misalign_s = (MemRead_in | MemWrite_in) &  XOut_in[0];
    assign mem_addr   = XOut_in;
    assign mem_wdata  = read2Data_in;

    // Request/stall outputs are combinational, so reset must kill them in the same instant.
    assign mem_rd    = rd_s & ~rst;
    assign mem_wr    = wr_s & ~rst;
    assign stall_out = stall_s & ~rst;

    // Write-back value select; a store (including read+write) never takes load data.
    assign wb_data_s = link_in ? PC_plus_two_in :
                       ((MemtoReg_in & ~MemWrite_in) ? mem_rdata : XOut_in);

    // Next-state, wait counter, memory request and WB entry selection.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        rd_s    = 1'b0;
        wr_s    = 1'b0;
        stall_s = 1'b0;
        entry_s = ENT_NORMAL;
        case (state_r)
            IDLE: begin
                rd_s = MemRead_in & ~MemWrite_in & memop_s;
                wr_s = MemWrite_in & memop_s;
                if (misalign_s) begin
                    entry_s = ENT_ERROR;
                end else if (memop_s & ~mem_done) begin
                    state_s = WAIT;
                    cnt_s   = 8'd1;
                    stall_s = 1'b1;
                    entry_s = ENT_BUBBLE;
                end else begin
                    entry_s = ENT_NORMAL;
                end
            end
            WAIT: begin
                rd_s = MemRead_in & ~MemWrite_in;
                wr_s = MemWrite_in;
                if (mem_done) begin
                    state_s = IDLE;
                    cnt_s   = 8'd0;
                    entry_s = ENT_NORMAL;
                end else if (cnt_r == 8'(MAX_WAIT)) begin
                    // Timeout: abandon the request and release the pipeline with an error entry.
                    rd_s    = 1'b0;
                    wr_s    = 1'b0;
                    state_s = IDLE;
                    cnt_s   = 8'd0;
                    entry_s = ENT_ERROR;
                end else begin
                    cnt_s   = cnt_r + 8'd1;
                    stall_s = 1'b1;
                    entry_s = ENT_BUBBLE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 8'd0;
                entry_s = ENT_BUBBLE;
            end
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // MEM/WB result registers; bubbles and errors keep the previous data/register fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid          <= 1'b0;
            wb_RegWrite       <= 1'b0;
            wb_Write_register <= 3'd0;
            wb_Write_data     <= 16'd0;
            wb_halt           <= 1'b0;
            wb_createdump     <= 1'b0;
            wb_err            <= 1'b0;
        end else begin
            case (entry_s)
                ENT_NORMAL: begin
                    wb_valid          <= 1'b1;
                    wb_RegWrite       <= RegWrite_in;
                    wb_Write_register <= Write_register_in;
                    wb_Write_data     <= wb_data_s;
                    wb_halt           <= halt_in;
                    wb_createdump     <= createdump_in;
                    wb_err            <= 1'b0;
                end
                ENT_ERROR: begin
                    wb_valid      <= 1'b1;
                    wb_RegWrite   <= 1'b0;
                    wb_halt       <= halt_in;
                    wb_createdump <= createdump_in;
                    wb_err        <= 1'b1;
                end
                default: begin
                    wb_valid      <= 1'b0;
                    wb_RegWrite   <= 1'b0;
                    wb_halt       <= 1'b0;
                    wb_createdump <= 1'b0;
                    wb_err        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed plan steps plus randomized
// transactions checked against a transaction-level reference model.
module tb_mem_stage;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] XOut_in = 16'd0, read2Data_in = 16'd0, PC_plus_two_in = 16'd0, mem_rdata = 16'd0;
    logic        MemWrite_in = 1'b0, MemRead_in = 1'b0, halt_in = 1'b0, createdump_in = 1'b0;
    logic        link_in = 1'b0, MemtoReg_in = 1'b0, RegWrite_in = 1'b0, mem_done = 1'b0;
    logic [2:0]  Write_register_in = 3'd0;
    logic [15:0] mem_addr, mem_wdata, wb_Write_data;
    logic        mem_rd, mem_wr, stall_out, wb_valid, wb_RegWrite, wb_halt, wb_createdump, wb_err;
    logic [2:0]  wb_Write_register;

    int checks = 0;
    int errors = 0;

    // Model state for the fields that bubbles hold.
    logic [15:0] exp_data = 16'd0;
    logic [2:0]  exp_reg  = 3'd0;
    bit          data_known = 1'b1;

    mem_stage #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .XOut_in(XOut_in), .read2Data_in(read2Data_in),
        .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in), .halt_in(halt_in),
        .createdump_in(createdump_in), .link_in(link_in), .PC_plus_two_in(PC_plus_two_in),
        .MemtoReg_in(MemtoReg_in), .Write_register_in(Write_register_in),
        .RegWrite_in(RegWrite_in), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .stall_out(stall_out), .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite),
        .wb_Write_register(wb_Write_register), .wb_Write_data(wb_Write_data),
        .wb_halt(wb_halt), .wb_createdump(wb_createdump), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bubble();
        chk("bub_valid", {15'd0, wb_valid}, 16'd0);
        chk("bub_regw", {15'd0, wb_RegWrite}, 16'd0);
        chk("bub_halt", {14'd0, wb_halt, wb_createdump}, 16'd0);
        chk("bub_err", {15'd0, wb_err}, 16'd0);
        chk("bub_reg", {13'd0, wb_Write_register}, {13'd0, exp_reg});
        if (data_known) chk("bub_data", wb_Write_data, exp_data);
    endtask

    // One instruction through the stage; memory completes in cycle d (0 = same cycle).
    task automatic run_op(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic lnk, input logic [15:0] pc2,
                          input logic mtr, input logic [2:0] wreg, input logic regw,
                          input logic hlt, input logic dmp, input int d, input int rdv);
        bit memop, misal, tmo;
        int last;
        logic [15:0] rdat;
        MemRead_in = rd; MemWrite_in = wr; XOut_in = addr; read2Data_in = wdata;
        link_in = lnk; PC_plus_two_in = pc2; MemtoReg_in = mtr; Write_register_in = wreg;
        RegWrite_in = regw; halt_in = hlt; createdump_in = dmp;
        memop = (rd || wr) && !addr[0];
        misal = (rd || wr) && addr[0];
        last  = memop ? ((d < MAXW) ? d : MAXW) : 0;
        tmo   = memop && (d > MAXW);
        for (int i = 0; i <= last; i++) begin
            rdat      = (rdv < 0) ? 16'($urandom) : 16'(rdv);
            mem_rdata = rdat;
            mem_done  = memop ? (i == d) : 1'($urandom);
            @(negedge clk);
            chk("stall", {15'd0, stall_out}, {15'd0, (i < last) ? 1'b1 : 1'b0});
            chk("addr", mem_addr, addr);
            chk("wdata", mem_wdata, wdata);
            if (!(tmo && i == last)) begin
                chk("mem_rd", {15'd0, mem_rd}, {15'd0, memop && rd && !wr});
                chk("mem_wr", {15'd0, mem_wr}, {15'd0, memop && wr});
            end
            @(posedge clk); #1;
            if (i < last) begin
                chk_bubble();
            end else if (misal || tmo) begin
                chk("err_valid", {15'd0, wb_valid}, 16'd1);
                chk("err_err", {15'd0, wb_err}, 16'd1);
                chk("err_regw", {15'd0, wb_RegWrite}, 16'd0);
                chk("err_hd", {14'd0, wb_halt, wb_createdump}, {14'd0, hlt, dmp});
                data_known = 1'b0;
            end else begin
                exp_data = lnk ? pc2 : ((mtr && !wr) ? rdat : addr);
                exp_reg  = wreg;
                data_known = 1'b1;
                chk("ok_valid", {15'd0, wb_valid}, 16'd1);
                chk("ok_err", {15'd0, wb_err}, 16'd0);
                chk("ok_regw", {15'd0, wb_RegWrite}, {15'd0, regw});
                chk("ok_reg", {13'd0, wb_Write_register}, {13'd0, wreg});
                chk("ok_data", wb_Write_data, exp_data);
                chk("ok_hd", {14'd0, wb_halt, wb_createdump}, {14'd0, hlt, dmp});
            end
        end
        mem_done = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_wb", {wb_valid, wb_RegWrite, wb_halt, wb_createdump, wb_err, wb_Write_register, 8'd0}, 16'd0);
        chk("rst_data", wb_Write_data, 16'd0);
        chk("rst_stall", {15'd0, stall_out}, 16'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // ADD pass-through
        run_op(1'b0, 1'b0, 16'h1234, 16'h0, 1'b0, 16'h0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 0, -1);
        // Single-cycle load
        run_op(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 16'h0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 0, 16'hBEEF);
        // Store, done on wait cycle 3
        run_op(1'b0, 1'b1, 16'h0100, 16'h5A5A, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3, -1);
        // Misaligned load
        run_op(1'b1, 1'b0, 16'h0041, 16'h0, 1'b0, 16'h0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 0, -1);
        // Timeout, then done exactly at MAX_WAIT
        run_op(1'b1, 1'b0, 16'h0080, 16'h0, 1'b0, 16'h0, 1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 1000, -1);
        run_op(1'b1, 1'b0, 16'h0080, 16'h0, 1'b0, 16'h0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, MAXW, 16'hC0DE);
        // Read and write together behave as a store
        run_op(1'b1, 1'b1, 16'h0200, 16'h1111, 1'b0, 16'h0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1, 16'hFFFF);

        // Reset during wait cycle 2
        MemRead_in = 1'b1; MemWrite_in = 1'b0; XOut_in = 16'h0040; MemtoReg_in = 1'b1;
        link_in = 1'b0; mem_done = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("w2_stall", {15'd0, stall_out}, 16'd1);
        chk("w2_rd", {15'd0, mem_rd}, 16'd1);
        rst = 1'b1; #1;
        chk("arst_rd", {15'd0, mem_rd}, 16'd0);
        chk("arst_stall", {15'd0, stall_out}, 16'd0);
        chk("arst_valid", {15'd0, wb_valid}, 16'd0);
        MemRead_in = 1'b0;
        exp_data = 16'd0; exp_reg = 3'd0; data_known = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        // JAL
        run_op(1'b0, 1'b0, 16'h0F0F, 16'h0, 1'b1, 16'h0022, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 0, -1);

        // Randomized transactions
        for (int n = 0; n < 60; n++) begin
            logic rd, wr;
            logic [15:0] a;
            rd = 1'($urandom);
            wr = ($urandom_range(0, 3) == 0) ? 1'b1 : ~rd & 1'($urandom);
            a  = 16'($urandom);
            if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
            run_op(rd, wr, a, 16'($urandom), ($urandom_range(0, 7) == 0), 16'($urandom),
                   1'($urandom), 3'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 9) == 0), $urandom_range(0, MAXW + 2), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
